// File: rtl/i2c_apb_arbiter_if.sv
// Bundles two requester ports, the shared response and the APB master pins
// of the I2C peripheral arbiter.
interface i2c_apb_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ack;

    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ack;

    logic              rsp_valid0;
    logic              rsp_valid1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;

    // Arbiter side: drives acks, responses and the APB request pins.
    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  PREADY, PRDATA,
        output req0_ack, req1_ack, rsp_valid0, rsp_valid1, rsp_rdata, rsp_err,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    // Environment side: requesters plus the APB slave.
    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output PREADY, PRDATA,
        input  req0_ack, req1_ack, rsp_valid0, rsp_valid1, rsp_rdata, rsp_err,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/i2c_apb_arbiter.sv
// Two-port round-robin APB master front end for the I2C peripheral.
// Sequences IDLE -> SETUP -> ACCESS, aborts stalled accesses after TIMEOUT
// wait cycles and returns data/status to the granted requester.
module i2c_apb_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input logic               PCLK,
    input logic               PRESET,
    i2c_apb_arbiter_if.master bus
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state, state_next;
    logic              last_grant, last_grant_next;
    logic              grant_port, grant_port_next;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
    logic              pick1;
    logic              timeout_hit;

    logic              psel_next, penable_next, pwrite_next;
    logic [ADDR_W-1:0] paddr_next;
    logic [DATA_W-1:0] pwdata_next;
    logic              ack0_next, ack1_next;
    logic              rsp_valid0_next, rsp_valid1_next;
    logic [DATA_W-1:0] rsp_rdata_next;
    logic              rsp_err_next;

    // last_grant = 1 means port 1 was served last, so port 0 wins a tie.
    assign pick1       = bus.req1_valid && (!bus.req0_valid || !last_grant);
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LIMIT);

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        grant_port_next = grant_port;
        wait_cnt_next   = wait_cnt;
        psel_next       = bus.PSELx;
        penable_next    = bus.PENABLE;
        pwrite_next     = bus.PWRITE;
        paddr_next      = bus.PADDR;
        pwdata_next     = bus.PWDATA;
        ack0_next       = 1'b0;
        ack1_next       = 1'b0;
        rsp_valid0_next = 1'b0;
        rsp_valid1_next = 1'b0;
        rsp_rdata_next  = bus.rsp_rdata;
        rsp_err_next    = bus.rsp_err;
        case (state)
            IDLE: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                if (bus.req0_valid || bus.req1_valid) begin
                    grant_port_next = pick1;
                    last_grant_next = pick1;
                    pwrite_next     = pick1 ? bus.req1_write : bus.req0_write;
                    paddr_next      = pick1 ? bus.req1_addr  : bus.req0_addr;
                    pwdata_next     = pick1 ? bus.req1_wdata : bus.req0_wdata;
                    ack0_next       = !pick1;
                    ack1_next       = pick1;
                    psel_next       = 1'b1;
                    state_next      = SETUP;
                end
            end
            SETUP: begin
                penable_next  = 1'b1;
                wait_cnt_next = CNT_ONE;
                state_next    = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY || timeout_hit) begin
                    rsp_rdata_next  = (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : '0;
                    rsp_err_next    = !bus.PREADY;
                    rsp_valid0_next = !grant_port;
                    rsp_valid1_next = grant_port;
                    psel_next       = 1'b0;
                    penable_next    = 1'b0;
                    state_next      = IDLE;
                end else if (wait_cnt != CNT_MAX) begin
                    wait_cnt_next = wait_cnt + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, arbitration pointer, wait counter and all outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            grant_port     <= 1'b0;
            wait_cnt       <= '0;
            bus.PSELx      <= 1'b0;
            bus.PENABLE    <= 1'b0;
            bus.PWRITE     <= 1'b0;
            bus.PADDR      <= '0;
            bus.PWDATA     <= '0;
            bus.req0_ack   <= 1'b0;
            bus.req1_ack   <= 1'b0;
            bus.rsp_valid0 <= 1'b0;
            bus.rsp_valid1 <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_err    <= 1'b0;
        end else begin
            state          <= state_next;
            last_grant     <= last_grant_next;
            grant_port     <= grant_port_next;
            wait_cnt       <= wait_cnt_next;
            bus.PSELx      <= psel_next;
            bus.PENABLE    <= penable_next;
            bus.PWRITE     <= pwrite_next;
            bus.PADDR      <= paddr_next;
            bus.PWDATA     <= pwdata_next;
            bus.req0_ack   <= ack0_next;
            bus.req1_ack   <= ack1_next;
            bus.rsp_valid0 <= rsp_valid0_next;
            bus.rsp_valid1 <= rsp_valid1_next;
            bus.rsp_rdata  <= rsp_rdata_next;
            bus.rsp_err    <= rsp_err_next;
        end
    end
endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Bench for i2c_apb_arbiter: two instances (TIMEOUT=4 and TIMEOUT=0) checked
// every cycle against a transaction-level model, plus directed scenarios.
module tb_i2c_apb_arbiter;
    localparam int NI    = 2;
    localparam int TMO_A = 4;
    localparam int TMO_B = 0;

    typedef struct packed {
        logic       ack0, ack1, rv0, rv1;
        logic [7:0] rdata;
        logic       err, psel, pen, pwrite;
        logic [7:0] paddr, pwdata;
    } obs_t;

    typedef struct packed {
        logic       v0, w0;
        logic [7:0] a0, d0;
        logic       v1, w1;
        logic [7:0] a1, d1;
        logic       ready;
        logic [7:0] rdata;
    } drv_t;

    logic clk = 1'b0;
    logic rst;
    drv_t drv [NI];
    obs_t obs [NI];
    obs_t exp_out [NI];

    bit   m_busy [NI];
    bit   m_port [NI];
    bit   m_last [NI];
    int   m_age  [NI];

    int   n_cmp = 0;
    int   n_err = 0;
    int   stall [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gi
        i2c_apb_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
        assign bus.req0_valid = drv[g].v0;
        assign bus.req0_write = drv[g].w0;
        assign bus.req0_addr  = drv[g].a0;
        assign bus.req0_wdata = drv[g].d0;
        assign bus.req1_valid = drv[g].v1;
        assign bus.req1_write = drv[g].w1;
        assign bus.req1_addr  = drv[g].a1;
        assign bus.req1_wdata = drv[g].d1;
        assign bus.PREADY     = drv[g].ready;
        assign bus.PRDATA     = drv[g].rdata;
        assign obs[g] = {bus.req0_ack, bus.req1_ack, bus.rsp_valid0, bus.rsp_valid1,
                         bus.rsp_rdata, bus.rsp_err, bus.PSELx, bus.PENABLE,
                         bus.PWRITE, bus.PADDR, bus.PWDATA};
        i2c_apb_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(g == 0 ? TMO_A : TMO_B)) dut (
            .PCLK  (clk),
            .PRESET(rst),
            .bus   (bus)
        );
    end

    function automatic int tmo_of(input int i);
        return (i == 0) ? TMO_A : TMO_B;
    endfunction

    // Transaction view: a transfer is alive from its ack cycle (age 0); each
    // later cycle is an access cycle numbered by age, ending on ready or timeout.
    task automatic model_step(input int i);
        obs_t e;
        bit   p;
        e = exp_out[i];
        e.ack0 = 1'b0; e.ack1 = 1'b0; e.rv0 = 1'b0; e.rv1 = 1'b0;
        if (rst) begin
            exp_out[i] = '0;
            m_busy[i]  = 1'b0;
            m_last[i]  = 1'b1;
            m_age[i]   = 0;
            return;
        end
        if (!m_busy[i]) begin
            e.psel = 1'b0;
            e.pen  = 1'b0;
            if (drv[i].v0 || drv[i].v1) begin
                p = (drv[i].v0 && drv[i].v1) ? !m_last[i] : drv[i].v1;
                m_last[i] = p;
                m_port[i] = p;
                m_busy[i] = 1'b1;
                m_age[i]  = 0;
                e.psel    = 1'b1;
                e.pwrite  = p ? drv[i].w1 : drv[i].w0;
                e.paddr   = p ? drv[i].a1 : drv[i].a0;
                e.pwdata  = p ? drv[i].d1 : drv[i].d0;
                e.ack0    = !p;
                e.ack1    = p;
            end
        end else if (m_age[i] == 0) begin
            e.pen    = 1'b1;
            m_age[i] = 1;
        end else if (drv[i].ready || (tmo_of(i) != 0 && m_age[i] == tmo_of(i))) begin
            e.rv0     = !m_port[i];
            e.rv1     = m_port[i];
            e.err     = !drv[i].ready;
            e.rdata   = (drv[i].ready && !e.pwrite) ? drv[i].rdata : 8'h00;
            e.psel    = 1'b0;
            e.pen     = 1'b0;
            m_busy[i] = 1'b0;
        end else begin
            m_age[i] = m_age[i] + 1;
        end
        exp_out[i] = e;
    endtask

    // Advance the reference model on every rising edge using the same inputs.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) model_step(i);
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    int cyc = 0;
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++)
            check_output($sformatf("cycle i%0d @%0d", i, cyc), obs[i], exp_out[i]);
    endtask

    task automatic set_req(input int i, input int p, input bit v, input bit w,
                           input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            drv[i].v0 = v; drv[i].w0 = w; drv[i].a0 = a; drv[i].d0 = d;
        end else begin
            drv[i].v1 = v; drv[i].w1 = w; drv[i].a1 = a; drv[i].d1 = d;
        end
    endtask

    task automatic apply_stimulus(input int i);
        if (!drv[i].v0 || obs[i].ack0)
            set_req(i, 0, ($urandom_range(0, 2) != 0), 1'($urandom), 8'($urandom), 8'($urandom));
        if (!drv[i].v1 || obs[i].ack1)
            set_req(i, 1, ($urandom_range(0, 2) != 0), 1'($urandom), 8'($urandom), 8'($urandom));
        if (stall[i] > 0) begin
            drv[i].ready = 1'b0;
            stall[i]--;
        end else if ($urandom_range(0, 9) == 0) begin
            stall[i]     = int'($urandom_range(2, 7));
            drv[i].ready = 1'b0;
        end else begin
            drv[i].ready = ($urandom_range(0, 3) != 0);
        end
        drv[i].rdata = 8'($urandom);
    endtask

    int order [$];
    int ack_at [$];
    int n_rv0, n_rv1, n_rv;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            drv[i] = '0;
            stall[i] = 0;
        end
        repeat (3) tick();
        check_output("reset outputs i0", obs[0], 32'h0);
        check_output("reset outputs i1", obs[1], 32'h0);
        rst = 1'b0;

        $display("[TB] single write, port 0");
        set_req(0, 0, 1'b1, 1'b1, 8'h04, 8'hA5);
        drv[0].ready = 1'b1;
        tick();
        check_output("t1 ack0 c1", obs[0].ack0, 1);
        check_output("t1 psel c1", obs[0].psel, 1);
        check_output("t1 pen c1", obs[0].pen, 0);
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        check_output("t1 psel c2", obs[0].psel, 1);
        check_output("t1 pen c2", obs[0].pen, 1);
        check_output("t1 paddr c2", obs[0].paddr, 8'h04);
        check_output("t1 pwdata c2", obs[0].pwdata, 8'hA5);
        check_output("t1 pwrite c2", obs[0].pwrite, 1);
        tick();
        check_output("t1 rv0 c3", obs[0].rv0, 1);
        check_output("t1 err c3", obs[0].err, 0);
        check_output("t1 psel c3", obs[0].psel, 0);

        $display("[TB] single read, port 1, two wait states");
        set_req(0, 1, 1'b1, 1'b0, 8'h08, 8'h00);
        drv[0].ready = 1'b0;
        tick();
        check_output("t2 ack1 c1", obs[0].ack1, 1);
        check_output("t2 paddr c1", obs[0].paddr, 8'h08);
        set_req(0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        check_output("t2 paddr c2", obs[0].paddr, 8'h08);
        tick();
        check_output("t2 paddr c3", obs[0].paddr, 8'h08);
        tick();
        check_output("t2 paddr c4", obs[0].paddr, 8'h08);
        check_output("t2 rv1 c4", obs[0].rv1, 0);
        drv[0].ready = 1'b1;
        drv[0].rdata = 8'h3C;
        tick();
        check_output("t2 rv1 c5", obs[0].rv1, 1);
        check_output("t2 rdata c5", obs[0].rdata, 8'h3C);

        $display("[TB] both ports valid, four transfers");
        set_req(0, 0, 1'b1, 1'b0, 8'h11, 8'h00);
        set_req(0, 1, 1'b1, 1'b0, 8'h22, 8'h00);
        drv[0].rdata = 8'h5A;
        n_rv0 = 0; n_rv1 = 0;
        for (int k = 1; k <= 30 && order.size() < 4; k++) begin
            tick();
            n_rv0 += int'(obs[0].rv0);
            n_rv1 += int'(obs[0].rv1);
            if (obs[0].ack0 || obs[0].ack1) begin
                order.push_back(int'(obs[0].ack1));
                ack_at.push_back(k);
                if (order.size() == 4) begin
                    set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
                    set_req(0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
                end
            end
        end
        repeat (3) begin
            tick();
            n_rv0 += int'(obs[0].rv0);
            n_rv1 += int'(obs[0].rv1);
        end
        check_output("t3 grant count", order.size(), 4);
        for (int j = 0; j < order.size(); j++) begin
            check_output($sformatf("t3 grant %0d port", j), order[j], j % 2);
            check_output($sformatf("t3 grant %0d cycle", j), ack_at[j], 1 + 3 * j);
        end
        check_output("t3 rsp count p0", n_rv0, 2);
        check_output("t3 rsp count p1", n_rv1, 2);

        $display("[TB] timeout abort with TIMEOUT=4");
        set_req(0, 0, 1'b1, 1'b0, 8'h10, 8'h00);
        drv[0].ready = 1'b0;
        drv[0].rdata = 8'hFF;
        tick();
        check_output("t4 ack0 c1", obs[0].ack0, 1);
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) tick();
        check_output("t4 psel c5", obs[0].psel, 1);
        check_output("t4 rv0 c5", obs[0].rv0, 0);
        tick();
        check_output("t4 rv0 c6", obs[0].rv0, 1);
        check_output("t4 err c6", obs[0].err, 1);
        check_output("t4 rdata c6", obs[0].rdata, 8'h00);
        check_output("t4 psel c6", obs[0].psel, 0);
        set_req(0, 1, 1'b1, 1'b1, 8'h30, 8'h99);
        drv[0].ready = 1'b1;
        tick();
        set_req(0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) tick();
        check_output("t4 follow rv1", obs[0].rv1, 1);
        check_output("t4 follow err", obs[0].err, 0);

        $display("[TB] TIMEOUT=0, long stall");
        set_req(1, 0, 1'b1, 1'b0, 8'h20, 8'h00);
        drv[1].ready = 1'b0;
        drv[1].rdata = 8'hEE;
        tick();
        check_output("t5 ack0 c1", obs[1].ack0, 1);
        set_req(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        n_rv = 0;
        for (int k = 2; k <= 302; k++) begin
            tick();
            n_rv += int'(obs[1].rv0) + int'(obs[1].rv1);
        end
        check_output("t5 no abort", n_rv, 0);
        check_output("t5 pen held", obs[1].pen, 1);
        drv[1].ready = 1'b1;
        drv[1].rdata = 8'h77;
        tick();
        check_output("t5 rv0", obs[1].rv0, 1);
        check_output("t5 err", obs[1].err, 0);
        check_output("t5 rdata", obs[1].rdata, 8'h77);

        $display("[TB] reset during access");
        set_req(0, 0, 1'b1, 1'b0, 8'h40, 8'h00);
        drv[0].ready = 1'b0;
        tick();
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_output("t6 reset i0", obs[0], 32'h0);
        check_output("t6 reset i1", obs[1], 32'h0);
        rst = 1'b0;
        set_req(0, 0, 1'b1, 1'b0, 8'h41, 8'h00);
        set_req(0, 1, 1'b1, 1'b0, 8'h42, 8'h00);
        drv[0].ready = 1'b1;
        tick();
        check_output("t6 first ack0", obs[0].ack0, 1);
        check_output("t6 first ack1", obs[0].ack1, 0);
        set_req(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick();
        check_output("t6 second ack1", obs[0].ack1, 1);
        set_req(0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick();

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NI; i++) apply_stimulus(i);
        end
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            set_req(i, 0, 1'b0, 1'b0, 8'h00, 8'h00);
            set_req(i, 1, 1'b0, 1'b0, 8'h00, 8'h00);
            drv[i].ready = 1'b1;
        end
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_apb_arbiter.md
# i2c_apb_arbiter

Two-port APB master front end for the I2C peripheral (`top_level`). It lets two requesters share the peripheral's APB slave port: typically a firmware/CPU-side register path and a DMA-style byte streamer. It arbitrates between them round-robin, sequences each access through APB SETUP/ACCESS phases, aborts stalled accesses after a programmable wait limit, and returns read data and status to the requester that was granted. It sits between the requesters and `top_level`'s PSELx/PENABLE/PWRITE/PADDR/PWDATA/PREADY/PRDATA pins, in the PCLK domain.

## Interface
Parameters:
- ADDR_W, 8, width of PADDR and request addresses
- DATA_W, 8, width of PWDATA/PRDATA and request data
- TIMEOUT, 255, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout

Ports:
- PCLK  in  1  single clock, rising edge
- PRESET  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has a transfer pending; held until req0_ack
- req0_write  in  1  1 = write, 0 = read
- req0_addr  in  ADDR_W  register address
- req0_wdata  in  DATA_W  write data
- req0_ack  out  1  one-cycle pulse: request 0 accepted, payload latched
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ack  (same as port 0)
- rsp_valid0  out  1  one-cycle pulse: port 0 transfer finished
- rsp_valid1  out  1  one-cycle pulse: port 1 transfer finished
- rsp_rdata  out  DATA_W  read data; valid with rsp_validN
- rsp_err  out  1  timeout abort flag; valid with rsp_validN
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PREADY  in  1  slave ready
- PRDATA  in  DATA_W  slave read data

## Operation
- FSM states are IDLE, SETUP and ACCESS. All outputs are registered.
- IDLE:
  - If any reqN_valid is high, pick a winner and latch its write/addr/wdata into PWRITE/PADDR/PWDATA.
  - Set PSELx=1 and pulse reqN_ack for the winner, then go to SETUP.
  - If no request is valid, PSELx=0 and PENABLE=0.
- Arbitration:
  - A single valid request wins outright.
  - If both are valid, the port not granted last wins.
  - The last-grant pointer updates only on a grant; after reset it favours port 0.
- SETUP: lasts exactly one cycle with PSELx=1, PENABLE=0, then goes to ACCESS.
- ACCESS: PSELx=1, PENABLE=1. The wait counter starts at 1 in the first ACCESS cycle.
  - PREADY=1: rsp_rdata = PRDATA for a read, 0 for a write. rsp_err=0. Pulse rsp_validN for the granted port. PSELx and PENABLE go to 0. Return to IDLE.
  - PREADY=0 with counter == TIMEOUT (TIMEOUT ≠ 0): rsp_rdata=0, rsp_err=1, pulse rsp_validN, PSELx and PENABLE go to 0, return to IDLE.
  - Otherwise: increment the counter and stay. Counter width is clog2(TIMEOUT+1), minimum 1. It never wraps; with TIMEOUT=0 it saturates.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the end of ACCESS. Requester inputs are ignored after ack.
- rsp_rdata and rsp_err hold their value until the next rsp_validN.
- Back-to-back transfers always pass through IDLE for at least one cycle, which is also the cycle rsp_validN is high.
- Reset (PRESET=1 at an edge):
  - State goes to IDLE, pointer favours port 0, counter clears.
  - Every output goes to 0: PSELx, PENABLE, PWRITE, PADDR, PWDATA, both acks, both rsp_valids, rsp_rdata, rsp_err.
  - Reset mid-transfer drops PSELx/PENABLE on that edge and emits no rsp_valid. The in-flight request counts as consumed.

## Timing
- Cycle 0: in IDLE, reqN_valid=1.
- Cycle 1: PSELx=1, PENABLE=0, reqN_ack=1.
- Cycle 2: PENABLE=1. If PREADY=1 here, rsp_validN=1 in cycle 3 with PSELx=0.
- Zero-wait throughput is one transfer per 3 cycles. Each wait state adds 1 cycle.
- Timeout: with PREADY held low, rsp_err asserts TIMEOUT+2 cycles after the ACCESS-entry cycle's predecessor, i.e. in cycle TIMEOUT+2 counted from cycle 0.
- A request that arrives while the arbiter is busy is granted in the first IDLE cycle after the response.

## Test plan
- Single write, port 0: addr=0x04, wdata=0xA5, PREADY tied to 1.
  - Required: ack in cycle 1, PSELx high cycles 1–2, PENABLE high cycle 2, rsp_valid0 in cycle 3, rsp_err=0.
- Single read, port 1: addr=0x08, slave returns PRDATA=0x3C after 2 wait states.
  - Required: rsp_rdata=0x3C, rsp_valid1 in cycle 5, PADDR stable in cycles 1–4.
- Both ports valid continuously, 4 transfers.
  - Required: grant order 0,1,0,1; an idle cycle between transfers; each ack paired with the matching rsp_valid.
- Timeout: TIMEOUT=4, PREADY held 0.
  - Required: rsp_err=1 and rsp_rdata=0 in cycle 6; PSELx low in cycle 6.
  - The next request then completes normally with rsp_err=0.
- TIMEOUT=0, PREADY low for 300 cycles then high.
  - Required: no abort, the transfer completes, rsp_err=0.
- PRESET asserted during ACCESS.
  - Required: next cycle all outputs are 0 and no rsp_valid fires.
  - With both ports valid after reset, port 0 is granted first.
